// File: rtl/sb_nav_sequencer.sv
// Navigation executor for the line-following bot: consumes a packed turn list and
// sequences both wheel channels through line following, node stops, turns and u-turn.
module sb_nav_sequencer #(
   parameter int MAX_TURNS        = 10,
   parameter int SPD_W            = 8,
   parameter int SPD_FWD          = 60,
   parameter int SPD_CORR         = 70,
   parameter int SPD_TURN         = 85,
   parameter int SPD_UTURN        = 80,
   parameter int NODE_FILT        = 8,
   parameter int NODE_DELAY_CYC   = 50_000_000,
   parameter int TURN_MIN_CYC     = 5_000_000,
   parameter int TURN_TIMEOUT_CYC = 150_000_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2*MAX_TURNS-1:0] path,
   input  logic                   path_valid,
   output logic                   path_ready,
   input  logic                   uturn_en,
   input  logic                   abort,
   input  logic                   l,
   input  logic                   c,
   input  logic                   r,
   output logic [SPD_W-1:0]       spd_l,
   output logic [SPD_W-1:0]       spd_r,
   output logic                   rev_l,
   output logic                   rev_r,
   output logic                   node_evt,
   output logic [1:0]             turn_code,
   output logic                   arrived,
   output logic                   busy,
   output logic                   fault
);

   localparam int IDX_W = $clog2(MAX_TURNS + 1);

   localparam logic [SPD_W-1:0] FWD_V   = SPD_W'(SPD_FWD);
   localparam logic [SPD_W-1:0] CORR_V  = SPD_W'(SPD_CORR);
   localparam logic [SPD_W-1:0] TURN_V  = SPD_W'(SPD_TURN);
   localparam logic [SPD_W-1:0] UTURN_V = SPD_W'(SPD_UTURN);
   localparam logic [SPD_W-1:0] ZERO_V  = {SPD_W{1'b0}};

   localparam logic [31:0] FILT_L    = 32'(NODE_FILT);
   localparam logic [31:0] DELAY_L   = 32'(NODE_DELAY_CYC - 1);
   localparam logic [31:0] MIN_L     = 32'(TURN_MIN_CYC);
   localparam logic [31:0] TIMEOUT_L = 32'(TURN_TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_TURNS);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FOLLOW    = 3'd1,
      S_NODE_FILT = 3'd2,
      S_NODE_WAIT = 3'd3,
      S_TURN      = 3'd4,
      S_UTURN     = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [2*MAX_TURNS-1:0] path_q, path_d;
   logic                   uturn_q, uturn_d;
   logic [SPD_W-1:0]       spd_l_q, spd_l_d;
   logic [SPD_W-1:0]       spd_r_q, spd_r_d;
   logic                   rev_l_q, rev_l_d;
   logic                   rev_r_q, rev_r_d;
   logic                   node_evt_q, node_evt_d;
   logic [1:0]             turn_code_q, turn_code_d;
   logic                   arrived_q, arrived_d;
   logic                   fault_q, fault_d;
   logic                   path_ready_q, path_ready_d;

   logic                   on_line;
   logic                   all_black;
   logic                   transfer;
   logic                   turn_exit;
   logic [SPD_W-1:0]       follow_l;
   logic [SPD_W-1:0]       follow_r;
   logic [1:0]             code_sel;

   assign on_line   = l & ~c & r;
   assign all_black = ~(l | c | r);
   assign transfer  = (state_q == S_IDLE) & path_valid & path_ready_q;

   // Line-following wheel command; unrecognised patterns keep the current command.
   always_comb begin
      follow_l = spd_l_q;
      follow_r = spd_r_q;
      if (on_line) begin
         follow_l = FWD_V;
         follow_r = FWD_V;
      end else if (~l & r) begin
         follow_l = ZERO_V;
         follow_r = CORR_V;
      end else if (l & ~r) begin
         follow_l = CORR_V;
         follow_r = ZERO_V;
      end else begin
         follow_l = spd_l_q;
         follow_r = spd_r_q;
      end
   end

   // Turn code at the current index; an exhausted path reads as destination.
   always_comb begin
      code_sel = 2'b00;
      for (int k = 0; k < MAX_TURNS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            code_sel = path_q[2*k +: 2];
         end else begin
            code_sel = code_sel;
         end
      end
   end

   // Straight-through exits as soon as the line reappears; left/right wait for a centred line.
   always_comb begin
      if (turn_code_q == 2'b11) begin
         turn_exit = ~all_black;
      end else begin
         turn_exit = on_line;
      end
   end

   // Next-state and registered-output computation for the sequencer.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      path_d       = path_q;
      uturn_d      = uturn_q;
      spd_l_d      = spd_l_q;
      spd_r_d      = spd_r_q;
      rev_l_d      = 1'b0;
      rev_r_d      = rev_r_q;
      node_evt_d   = 1'b0;
      turn_code_d  = turn_code_q;
      arrived_d    = 1'b0;
      path_ready_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            spd_l_d = ZERO_V;
            spd_r_d = ZERO_V;
            rev_r_d = 1'b0;
            if (transfer) begin
               path_d  = path;
               uturn_d = uturn_en;
               idx_d   = {IDX_W{1'b0}};
               spd_l_d = follow_l;
               spd_r_d = follow_r;
               state_d = S_FOLLOW;
            end else begin
               path_ready_d = 1'b1;
            end
         end
         S_FOLLOW: begin
            if (all_black) begin
               state_d = S_NODE_FILT;
            end else begin
               spd_l_d = follow_l;
               spd_r_d = follow_r;
            end
         end
         S_NODE_FILT: begin
            if (!all_black) begin
               state_d = S_FOLLOW;
            end else if ((cnt_q + 32'd1) >= FILT_L) begin
               spd_l_d = ZERO_V;
               spd_r_d = ZERO_V;
               state_d = S_NODE_WAIT;
            end else begin
               state_d = S_NODE_FILT;
            end
         end
         S_NODE_WAIT: begin
            spd_l_d = ZERO_V;
            spd_r_d = ZERO_V;
            if (cnt_q >= DELAY_L) begin
               node_evt_d  = 1'b1;
               turn_code_d = code_sel;
               if (idx_q != IDX_MAX) begin
                  idx_d = idx_q + IDX_W'(1);
               end else begin
                  idx_d = idx_q;
               end
               case (code_sel)
                  2'b01: begin
                     spd_r_d = TURN_V;
                     state_d = S_TURN;
                  end
                  2'b10: begin
                     spd_l_d = TURN_V;
                     state_d = S_TURN;
                  end
                  2'b11: begin
                     spd_l_d = FWD_V;
                     spd_r_d = FWD_V;
                     state_d = S_TURN;
                  end
                  default: begin
                     if (uturn_q) begin
                        spd_l_d = UTURN_V;
                        spd_r_d = UTURN_V;
                        rev_r_d = 1'b1;
                        state_d = S_UTURN;
                     end else begin
                        arrived_d = 1'b1;
                        state_d   = S_IDLE;
                     end
                  end
               endcase
            end else begin
               state_d = S_NODE_WAIT;
            end
         end
         S_TURN: begin
            if ((cnt_q >= MIN_L) && turn_exit) begin
               spd_l_d = follow_l;
               spd_r_d = follow_r;
               state_d = S_FOLLOW;
            end else if (cnt_q >= TIMEOUT_L) begin
               spd_l_d = ZERO_V;
               spd_r_d = ZERO_V;
               state_d = S_FAULT;
            end else begin
               state_d = S_TURN;
            end
         end
         S_UTURN: begin
            if ((cnt_q >= MIN_L) && on_line) begin
               spd_l_d   = ZERO_V;
               spd_r_d   = ZERO_V;
               rev_r_d   = 1'b0;
               arrived_d = 1'b1;
               state_d   = S_IDLE;
            end else if (cnt_q >= TIMEOUT_L) begin
               spd_l_d = ZERO_V;
               spd_r_d = ZERO_V;
               rev_r_d = 1'b0;
               state_d = S_FAULT;
            end else begin
               state_d = S_UTURN;
            end
         end
         S_FAULT: begin
            spd_l_d = ZERO_V;
            spd_r_d = ZERO_V;
            rev_r_d = 1'b0;
            state_d = S_FAULT;
         end
         default: begin
            spd_l_d = ZERO_V;
            spd_r_d = ZERO_V;
            rev_r_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      // Abort discards the path and overrides every transition above.
      if (abort) begin
         state_d      = S_IDLE;
         idx_d        = {IDX_W{1'b0}};
         spd_l_d      = ZERO_V;
         spd_r_d      = ZERO_V;
         rev_r_d      = 1'b0;
         node_evt_d   = 1'b0;
         arrived_d    = 1'b0;
         path_ready_d = 1'b1;
      end else begin
         path_ready_d = path_ready_d;
      end

      fault_d = (state_d == S_FAULT);

      if (state_d != state_q) begin
         cnt_d = 32'd0;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // State, counter and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 32'd0;
         idx_q        <= {IDX_W{1'b0}};
         path_q       <= {(2*MAX_TURNS){1'b0}};
         uturn_q      <= 1'b0;
         spd_l_q      <= ZERO_V;
         spd_r_q      <= ZERO_V;
         rev_l_q      <= 1'b0;
         rev_r_q      <= 1'b0;
         node_evt_q   <= 1'b0;
         turn_code_q  <= 2'b00;
         arrived_q    <= 1'b0;
         fault_q      <= 1'b0;
         path_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         path_q       <= path_d;
         uturn_q      <= uturn_d;
         spd_l_q      <= spd_l_d;
         spd_r_q      <= spd_r_d;
         rev_l_q      <= rev_l_d;
         rev_r_q      <= rev_r_d;
         node_evt_q   <= node_evt_d;
         turn_code_q  <= turn_code_d;
         arrived_q    <= arrived_d;
         fault_q      <= fault_d;
         path_ready_q <= path_ready_d;
      end
   end

   assign path_ready = path_ready_q;
   assign busy       = ~path_ready_q;
   assign spd_l      = spd_l_q;
   assign spd_r      = spd_r_q;
   assign rev_l      = rev_l_q;
   assign rev_r      = rev_r_q;
   assign node_evt   = node_evt_q;
   assign turn_code  = turn_code_q;
   assign arrived    = arrived_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_sb_nav_sequencer.sv
// Directed bench for sb_nav_sequencer: node/arrival events are scoreboarded through
// a queue, motor/handshake/fault outputs are checked at each directed step.
module tb_sb_nav_sequencer;

   localparam int MT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2*MT-1:0] path;
   logic          path_valid, path_ready, uturn_en, abort;
   logic          l, c, r;
   logic [7:0]    spd_l, spd_r;
   logic          rev_l, rev_r, node_evt, arrived, busy, fault;
   logic [1:0]    turn_code;

   int checks   = 0;
   int failures = 0;
   logic [3:0] exp_q[$];

   sb_nav_sequencer #(
      .MAX_TURNS(MT), .SPD_W(8), .SPD_FWD(60), .SPD_CORR(70), .SPD_TURN(85),
      .SPD_UTURN(80), .NODE_FILT(2), .NODE_DELAY_CYC(4), .TURN_MIN_CYC(3),
      .TURN_TIMEOUT_CYC(20)
   ) dut (
      .clk(clk), .rst_n(rst_n), .path(path), .path_valid(path_valid),
      .path_ready(path_ready), .uturn_en(uturn_en), .abort(abort),
      .l(l), .c(c), .r(r), .spd_l(spd_l), .spd_r(spd_r), .rev_l(rev_l),
      .rev_r(rev_r), .node_evt(node_evt), .turn_code(turn_code),
      .arrived(arrived), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lcr(input logic [2:0] v);
      {l, c, r} = v;
   endtask

   // Event scoreboard: every node_evt/arrived pulse must match the next queued entry.
   always @(negedge clk) begin
      if (rst_n && (node_evt || arrived)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {28'd0, node_evt, arrived, turn_code}, 32'd0);
         end else begin
            chk("event", {28'd0, node_evt, arrived, turn_code}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic start_path(input logic [7:0] p, input logic u);
      chk("pre_ready", path_ready, 1);
      path = p; uturn_en = u; path_valid = 1'b1;
      step();
      path_valid = 1'b0; path = ~p; uturn_en = ~u;
      chk("xfer_ready", path_ready, 0);
      chk("xfer_busy", busy, 1);
      chk("xfer_spd_l", spd_l, 60);
      chk("xfer_spd_r", spd_r, 60);
   endtask

   // Drive a node from FOLLOW, then expect node_evt exactly 4 cycles after the stop.
   task automatic node_wait(input int el, input int er);
      int n;
      set_lcr(3'b000);
      step();
      chk("filt_hold", (spd_l != 0) || (spd_r != 0), 1);
      step();
      step();
      chk("node_stop_l", spd_l, 0);
      chk("node_stop_r", spd_r, 0);
      n = 0;
      while (n < 10) begin
         step();
         n++;
         if (node_evt) break;
         chk("wait_motor0", {24'd0, spd_l | spd_r}, 0);
      end
      chk("node_delay", n, 4);
      chk("turn_spd_l", spd_l, el);
      chk("turn_spd_r", spd_r, er);
   endtask

   task automatic turn_exit(input int el, input int er);
      set_lcr(3'b101);
      repeat (3) begin
         step();
         chk("turn_hold_l", spd_l, el);
         chk("turn_hold_r", spd_r, er);
      end
      step();
      chk("exit_spd_l", spd_l, 60);
      chk("exit_spd_r", spd_r, 60);
   endtask

   initial begin
      rst_n = 1'b0; path = '0; path_valid = 1'b0; uturn_en = 1'b0; abort = 1'b0;
      set_lcr(3'b101);
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("rst_ready", path_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_spd", {16'd0, spd_l, spd_r}, 0);
      chk("rst_rev", {rev_l, rev_r}, 0);
      chk("rst_fault", fault, 0);
      chk("rst_code", turn_code, 0);

      // Main path: left, right, straight, destination.
      exp_q.push_back(4'b1001); exp_q.push_back(4'b1010);
      exp_q.push_back(4'b1011); exp_q.push_back(4'b1100);
      start_path(8'b00_11_10_01, 1'b0);
      set_lcr(3'b011); step();
      chk("drift_l", spd_l, 0); chk("drift_r", spd_r, 70);
      set_lcr(3'b110); step();
      chk("drift2_l", spd_l, 70); chk("drift2_r", spd_r, 0);
      set_lcr(3'b111); step();
      chk("hold_l", spd_l, 70); chk("hold_r", spd_r, 0);
      set_lcr(3'b101); step();
      chk("line_l", spd_l, 60); chk("line_r", spd_r, 60);
      node_wait(0, 85);  turn_exit(0, 85);
      node_wait(85, 0);  turn_exit(85, 0);
      node_wait(60, 60); turn_exit(60, 60);
      node_wait(0, 0);
      chk("dest_arrived", arrived, 1);
      chk("dest_ready_low", path_ready, 0);
      set_lcr(3'b101);
      step();
      chk("dest_ready", path_ready, 1);
      chk("dest_arrived_pulse", arrived, 0);

      // Glitch followed by u-turn destination.
      exp_q.push_back(4'b1000); exp_q.push_back(4'b0100);
      start_path(8'h00, 1'b1);
      set_lcr(3'b000); step();
      chk("glitch0", (spd_l != 0) && (spd_r != 0), 1);
      set_lcr(3'b101);
      repeat (3) begin
         step();
         chk("glitch_motor", (spd_l != 0) && (spd_r != 0), 1);
      end
      node_wait(80, 80);
      chk("uturn_rev_r", rev_r, 1);
      chk("uturn_rev_l", rev_l, 0);
      set_lcr(3'b101);
      repeat (3) begin
         step();
         chk("uturn_hold", {spd_l, spd_r, 7'd0, rev_r}, {8'd80, 8'd80, 8'd1});
      end
      step();
      chk("uturn_arrived", arrived, 1);
      chk("uturn_stop", {spd_l, spd_r, 7'd0, rev_r}, 0);
      chk("uturn_ready_low", path_ready, 0);
      step();
      chk("uturn_ready", path_ready, 1);

      // Turn timeout into sticky fault, cleared by abort.
      exp_q.push_back(4'b1001);
      start_path(8'b00_00_00_01, 1'b0);
      node_wait(0, 85);
      repeat (19) step();
      chk("pre_timeout_fault", fault, 0);
      chk("pre_timeout_spd", spd_r, 85);
      step();
      chk("timeout_fault", fault, 1);
      chk("timeout_spd", {16'd0, spd_l, spd_r}, 0);
      chk("timeout_ready", path_ready, 0);
      path = 8'hFF; path_valid = 1'b1;
      repeat (3) step();
      path_valid = 1'b0;
      chk("fault_ignores_valid", path_ready, 0);
      chk("fault_sticky", fault, 1);
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_fault", fault, 0);
      chk("abort_ready", path_ready, 1);
      set_lcr(3'b101);
      step();

      // Exhaustion: four straights then implicit destination.
      repeat (4) exp_q.push_back(4'b1011);
      exp_q.push_back(4'b1100);
      start_path(8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         node_wait(60, 60);
         turn_exit(60, 60);
      end
      node_wait(0, 0);
      chk("exh_arrived", arrived, 1);
      chk("exh_code", turn_code, 0);
      set_lcr(3'b101);
      step();
      chk("exh_ready", path_ready, 1);

      // Abort in the middle of a node stop.
      start_path(8'b00_00_00_01, 1'b0);
      set_lcr(3'b000);
      repeat (3) step();
      chk("abort_node_stop", {16'd0, spd_l, spd_r}, 0);
      step();
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_idle_ready", path_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_no_arrived", arrived, 0);
      chk("abort_no_evt", node_evt, 0);
      repeat (8) step();
      chk("abort_stays_idle", path_ready, 1);
      chk("abort_motors", {16'd0, spd_l, spd_r}, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
